// File: rtl/pl_ex_pkg.sv
// Shared types and constants for the multi-cycle RNS execute stage.
package pl_ex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_DOM_WID = 8;

    // Field order of branch_conds_EX counted from the MSB: {gt, lt, eq, carry, compare}
    localparam int BC_GT  = 0;
    localparam int BC_LT  = 1;
    localparam int BC_EQ  = 2;
    localparam int BC_CY  = 3;
    localparam int BC_CMP = 4;

    function automatic int bc_bit(input int idx);
        return 4 - idx;
    endfunction

endpackage

// File: rtl/rns_modmul_step.sv
// One MSB-first shift-add step of a modular multiply for a single residue domain.
module rns_modmul_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] acc,
    input  logic         bit_in,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] acc_next
);

    logic [W:0] m_ext;
    logic [W:0] dbl;
    logic [W:0] dbl_r;
    logic [W:0] sum;

    // m == 0 selects plain 2^W wrap instead of a conditional subtract
    always_comb begin
        m_ext = {1'b0, m};
        dbl   = {acc, 1'b0};
        if (m == '0)
            dbl_r = {1'b0, dbl[W-1:0]};
        else if (dbl >= m_ext)
            dbl_r = dbl - m_ext;
        else
            dbl_r = dbl;

        sum = dbl_r + (bit_in ? {1'b0, b} : '0);
        if (m == '0)
            acc_next = sum[W-1:0];
        else if (sum >= m_ext)
            acc_next = W'(sum - m_ext);
        else
            acc_next = sum[W-1:0];
    end

endmodule

// File: rtl/pl_ex_mc.sv
// Multi-cycle EX stage: single-cycle ALU pass-through plus sequential per-domain
// modular multiply, with valid/ready on both sides and a synchronous flush.
module pl_ex_mc
    import pl_ex_pkg::*;
#(
    parameter int NUM_DOMAINS  = 1,
    parameter int DOM_WID      = DEF_DOM_WID,
    parameter logic [NUM_DOMAINS*DOM_WID-1:0] MODULI = (NUM_DOMAINS*DOM_WID)'(251),
    parameter int PROG_CTR_WID = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    input  logic [NUM_DOMAINS*DOM_WID-1:0]  op1,
    input  logic [NUM_DOMAINS*DOM_WID-1:0]  op2,
    input  logic [NUM_DOMAINS*DOM_WID-1:0]  op3,
    input  logic [2:0]                      res_addr,
    input  logic [PROG_CTR_WID-1:0]         pred_nxt_prog_ctr,
    input  logic                            is_mul,
    input  logic                            store_true,
    input  logic                            load_true,
    input  logic                            ld_imm,
    input  logic                            write_to_regfile,
    input  logic                            compare_true,
    input  logic                            save_cout,
    input  logic [DOM_WID-1:0]              imm,
    input  logic [NUM_DOMAINS*DOM_WID-1:0]  alu_dout,
    input  logic                            alu_cout,
    input  logic                            alu_gt,
    input  logic                            alu_lt,
    input  logic                            alu_eq,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_DOMAINS*DOM_WID-1:0]  operation_result,
    output logic [2:0]                      destination_reg_addr,
    output logic                            reg_wr_en,
    output logic                            store_to_mem,
    output logic                            load_true_EX,
    output logic [2*DOM_WID-1:0]            data_wr_addr,
    output logic [2*DOM_WID-1:0]            data_rd_addr,
    output logic [4:0]                      branch_conds_EX,
    output logic [PROG_CTR_WID-1:0]         pred_nxt_prog_ctr_EX,
    output logic                            busy
);

    localparam int TW = NUM_DOMAINS * DOM_WID;
    localparam int CW = (DOM_WID > 1) ? $clog2(DOM_WID) : 1;

    state_t                  state;
    logic [CW-1:0]           bit_cnt;
    logic [TW-1:0]           acc, acc_next;
    logic [TW-1:0]           c_op1, c_op2, c_op3;
    logic [DOM_WID-1:0]      c_imm;
    logic                    c_store, c_load, c_ldimm, c_wr;
    logic [2:0]              c_res_addr;
    logic [PROG_CTR_WID-1:0] c_pc;
    logic                    wr_q, st_q, ld_q;

    logic                    out_free, take, load_out, from_cap;
    logic                    s_store, s_load, s_ldimm, s_wr;
    logic [2:0]              s_res_addr;
    logic [PROG_CTR_WID-1:0] s_pc;
    logic [TW-1:0]           s_op1, s_op2, s_op3, mul_val, res_nxt;
    logic [DOM_WID-1:0]      s_imm;
    logic [2*DOM_WID-1:0]    addr_nxt;
    logic [4:0]              bc_nxt;

    assign out_free     = !out_valid || out_ready;
    assign in_ready     = !reset && (state == IDLE) && out_free;
    assign take         = in_valid && in_ready;
    assign busy         = (state != IDLE);
    assign reg_wr_en    = out_valid && wr_q;
    assign store_to_mem = out_valid && st_q;
    assign load_true_EX = out_valid && ld_q;

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
        localparam int LO = (NUM_DOMAINS - 1 - g) * DOM_WID;
        logic [DOM_WID-1:0] a_dom;
        assign a_dom = c_op1[LO +: DOM_WID];
        rns_modmul_step #(.W(DOM_WID)) u_step (
            .acc      (acc[LO +: DOM_WID]),
            .bit_in   (a_dom[bit_cnt]),
            .b        (c_op2[LO +: DOM_WID]),
            .m        (MODULI[LO +: DOM_WID]),
            .acc_next (acc_next[LO +: DOM_WID])
        );
    end

    // Outside IDLE the output is always a completing multiply built from captured fields
    always_comb begin
        from_cap   = (state != IDLE);
        s_store    = from_cap ? c_store    : store_true;
        s_load     = from_cap ? c_load     : load_true;
        s_ldimm    = from_cap ? c_ldimm    : ld_imm;
        s_wr       = from_cap ? c_wr       : write_to_regfile;
        s_res_addr = from_cap ? c_res_addr : res_addr;
        s_pc       = from_cap ? c_pc       : pred_nxt_prog_ctr;
        s_op1      = from_cap ? c_op1      : op1;
        s_op2      = from_cap ? c_op2      : op2;
        s_op3      = from_cap ? c_op3      : op3;
        s_imm      = from_cap ? c_imm      : imm;
        mul_val    = (state == MUL) ? acc_next : acc;

        if (s_store)      res_nxt = s_op3;
        else if (s_ldimm) res_nxt = {NUM_DOMAINS{s_imm}};
        else if (from_cap) res_nxt = mul_val;
        else              res_nxt = alu_dout;

        addr_nxt = {s_op2[TW-1 -: DOM_WID], s_op1[TW-1 -: DOM_WID]};

        bc_nxt = '0;
        if (!from_cap) begin
            bc_nxt[bc_bit(BC_GT)]  = alu_gt;
            bc_nxt[bc_bit(BC_LT)]  = alu_lt;
            bc_nxt[bc_bit(BC_EQ)]  = alu_eq;
            bc_nxt[bc_bit(BC_CY)]  = save_cout && alu_cout;
            bc_nxt[bc_bit(BC_CMP)] = compare_true;
        end

        load_out = ((state == IDLE) && take && !is_mul)
                || ((state == MUL) && (bit_cnt == '0) && out_free)
                || ((state == HOLD) && out_free);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            bit_cnt              <= '0;
            acc                  <= '0;
            c_op1                <= '0;
            c_op2                <= '0;
            c_op3                <= '0;
            c_imm                <= '0;
            c_store              <= 1'b0;
            c_load               <= 1'b0;
            c_ldimm              <= 1'b0;
            c_wr                 <= 1'b0;
            c_res_addr           <= '0;
            c_pc                 <= '0;
            out_valid            <= 1'b0;
            operation_result     <= '0;
            destination_reg_addr <= '0;
            wr_q                 <= 1'b0;
            st_q                 <= 1'b0;
            ld_q                 <= 1'b0;
            data_wr_addr         <= '0;
            data_rd_addr         <= '0;
            branch_conds_EX      <= '0;
            pred_nxt_prog_ctr_EX <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end else begin
            if (load_out) begin
                out_valid            <= 1'b1;
                operation_result     <= res_nxt;
                destination_reg_addr <= s_res_addr;
                wr_q                 <= s_wr;
                st_q                 <= s_store;
                ld_q                 <= s_load;
                data_wr_addr         <= s_store ? addr_nxt : '0;
                data_rd_addr         <= s_load  ? addr_nxt : '0;
                branch_conds_EX      <= bc_nxt;
                pred_nxt_prog_ctr_EX <= s_pc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: if (take && is_mul) begin
                    c_op1      <= op1;
                    c_op2      <= op2;
                    c_op3      <= op3;
                    c_imm      <= imm;
                    c_store    <= store_true;
                    c_load     <= load_true;
                    c_ldimm    <= ld_imm;
                    c_wr       <= write_to_regfile;
                    c_res_addr <= res_addr;
                    c_pc       <= pred_nxt_prog_ctr;
                    acc        <= '0;
                    bit_cnt    <= CW'(DOM_WID - 1);
                    state      <= MUL;
                end
                MUL: begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt - CW'(1);
                    if (bit_cnt == '0)
                        state <= out_free ? IDLE : HOLD;
                end
                HOLD: if (out_free) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
